// File: rtl/rr_merger_pkg.sv
// -----------------------------------------------------------------------------
// rr_merger_pkg
// Shared constants and helpers for the round-robin merger:
//   DEF_SIZE   default number of upstream requesters
//   DEF_WIDTH  default data width per requester
//   idx_width  grant index width, max(1, clog2(size))
// -----------------------------------------------------------------------------
package rr_merger_pkg;

   localparam int DEF_SIZE  = 8;
   localparam int DEF_WIDTH = 32;

   // A single requester still needs a one-bit index, hence the floor of 1.
   function automatic int idx_width(input int size);
      int w;
      w = $clog2(size);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational cyclic priority search: returns the first set bit of req,
// starting at position ptr and wrapping upward through SIZE-1 back to 0.
// Ports:
//   req    SIZE-bit request vector
//   ptr    search start position (always < SIZE)
//   grant  index of the selected requester (0 when none)
//   any    at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int SIZE = 2,
   parameter int IDXW = 1
) (
   input  logic [SIZE-1:0] req,
   input  logic [IDXW-1:0] ptr,
   output logic [IDXW-1:0] grant,
   output logic            any
);

   // Scan from the farthest offset down to offset 0 so the nearest request
   // to ptr is the last assignment and therefore wins, without a break.
   always_comb begin : search
      int idx;
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      idx   = 0;
      grant = '0;
      any   = 1'b0;
      for (int k = SIZE - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % SIZE;
         if (req[idx]) begin
            grant = IDXW'(idx);
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_merger.sv
// -----------------------------------------------------------------------------
// rr_merger
// Round-robin merge of SIZE valid/ready streams into one registered stream.
// One beat per cycle is sustained while the downstream is ready; the output
// register drains and reloads in the same cycle.
// Ports:
//   iClk       clock, rising edge
//   iRst       asynchronous active-high reset
//   iValid_AS  per-requester valid
//   oReady_AS  per-requester ready, one-hot at the grant when a load occurs
//   iData_AS   requester i data at [i*WIDTH +: WIDTH]
//   oValid_BM  merged stream valid
//   iReady_BM  merged stream ready
//   oData_BM   merged data
//   oSel_BM    index of the requester that sourced oData_BM
//   iLast_AS   per-requester end-of-packet   (RR_MERGER_PKT_LOCK_EN only)
//   oLast_BM   merged end-of-packet          (RR_MERGER_PKT_LOCK_EN only)
// Configuration:
//   RR_MERGER_PKT_LOCK_EN  when defined, a requester keeps the grant from a
//                          load with last=0 until its load with last=1.
// -----------------------------------------------------------------------------
module rr_merger
   import rr_merger_pkg::*;
#(
   parameter  int SIZE  = DEF_SIZE,
   parameter  int WIDTH = DEF_WIDTH,
   localparam int IDXW  = idx_width(SIZE)
) (
   input  logic                    iClk,
   input  logic                    iRst,
   input  logic [SIZE-1:0]         iValid_AS,
   output logic [SIZE-1:0]         oReady_AS,
   input  logic [SIZE*WIDTH-1:0]   iData_AS,
`ifdef RR_MERGER_PKT_LOCK_EN
   input  logic [SIZE-1:0]         iLast_AS,
   output logic                    oLast_BM,
`endif
   output logic                    oValid_BM,
   input  logic                    iReady_BM,
   output logic [WIDTH-1:0]        oData_BM,
   output logic [IDXW-1:0]         oSel_BM
);

   logic [IDXW-1:0] ptr;
   logic [IDXW-1:0] grant;
   logic [IDXW-1:0] next_ptr;
   logic [SIZE-1:0] req;
   logic            any;
   logic            load;

`ifdef RR_MERGER_PKT_LOCK_EN
   logic            locked;
   logic [IDXW-1:0] lock_idx;
   logic            grant_last;

   // While a packet is open only its owner may be picked; masking the
   // request vector makes the search return the owner regardless of ptr.
   always_comb begin
      req = iValid_AS;
      if (locked) begin
         req           = '0;
         req[lock_idx] = iValid_AS[lock_idx];
      end
   end

   assign grant_last = iLast_AS[grant];
`else
   assign req = iValid_AS;
`endif

   rr_pick #(
      .SIZE (SIZE),
      .IDXW (IDXW)
   ) u_pick (
      .req   (req),
      .ptr   (ptr),
      .grant (grant),
      .any   (any)
   );

   // The output register can take a new beat when empty or being drained.
   assign load = any && (!oValid_BM || iReady_BM);

   assign next_ptr = (grant == IDXW'(SIZE - 1)) ? '0 : grant + 1'b1;

   // Ready is forced low during reset so nothing is accepted into a register
   // that is being cleared.
   always_comb begin
      oReady_AS = '0;
      if (load && !iRst) begin
         oReady_AS[grant] = 1'b1;
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         oValid_BM <= 1'b0;
         oData_BM  <= '0;
         oSel_BM   <= '0;
         ptr       <= '0;
`ifdef RR_MERGER_PKT_LOCK_EN
         oLast_BM  <= 1'b0;
         locked    <= 1'b0;
         lock_idx  <= '0;
`endif
      end else if (load) begin
         oValid_BM <= 1'b1;
         oData_BM  <= iData_AS[int'(grant)*WIDTH +: WIDTH];
         oSel_BM   <= grant;
`ifdef RR_MERGER_PKT_LOCK_EN
         oLast_BM  <= grant_last;
         if (grant_last) begin
            ptr    <= next_ptr;
            locked <= 1'b0;
         end else begin
            locked   <= 1'b1;
            lock_idx <= grant;
         end
`else
         ptr       <= next_ptr;
`endif
      end else if (iReady_BM) begin
         // Drain without reload: data and select keep their last values.
         oValid_BM <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_merger.sv
// -----------------------------------------------------------------------------
// tb_rr_merger
// Self-checking bench for rr_merger with SIZE=4, WIDTH=8. Directed scenarios
// followed by random traffic, all compared against a reference model that
// chooses the grant as the valid requester at the smallest cyclic distance
// from the pointer. Inputs change on the falling edge; combinational ready is
// checked just after, registered outputs on the next falling edge.
// -----------------------------------------------------------------------------
module tb_rr_merger;

   localparam int SIZE  = 4;
   localparam int WIDTH = 8;

   logic                  iClk = 1'b0;
   logic                  iRst;
   logic [SIZE-1:0]       iValid_AS;
   logic [SIZE-1:0]       oReady_AS;
   logic [SIZE*WIDTH-1:0] iData_AS;
   logic                  oValid_BM;
   logic                  iReady_BM;
   logic [WIDTH-1:0]      oData_BM;
   logic [1:0]            oSel_BM;
`ifdef RR_MERGER_PKT_LOCK_EN
   logic [SIZE-1:0]       iLast_AS;
   logic                  oLast_BM;
`endif

   rr_merger #(
      .SIZE  (SIZE),
      .WIDTH (WIDTH)
   ) dut (
      .iClk      (iClk),
      .iRst      (iRst),
      .iValid_AS (iValid_AS),
      .oReady_AS (oReady_AS),
      .iData_AS  (iData_AS),
`ifdef RR_MERGER_PKT_LOCK_EN
      .iLast_AS  (iLast_AS),
      .oLast_BM  (oLast_BM),
`endif
      .oValid_BM (oValid_BM),
      .iReady_BM (iReady_BM),
      .oData_BM  (oData_BM),
      .oSel_BM   (oSel_BM)
   );

   always #5 iClk = ~iClk;

   int n_pass  = 0;
   int n_total = 0;

   // reference model state
   logic       m_valid;
   logic [7:0] m_data;
   int         m_sel;
   int         m_ptr;
   int         last_g;
   int         waits [SIZE];
   logic [7:0] dat   [SIZE];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive_data();
      for (int i = 0; i < SIZE; i++) iData_AS[i*WIDTH +: WIDTH] = dat[i];
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = 0;
      m_ptr   = 0;
      last_g  = -1;
      for (int i = 0; i < SIZE; i++) waits[i] = 0;
   endtask

   // Valid requester with the smallest distance (i - p) mod SIZE.
   function automatic int mdl_grant(input logic [SIZE-1:0] v, input int p);
      int best, bestd, d;
      best  = -1;
      bestd = SIZE;
      for (int i = 0; i < SIZE; i++) begin
         d = (i - p + SIZE) % SIZE;
         if (v[i] && d < bestd) begin
            bestd = d;
            best  = i;
         end
      end
      return best;
   endfunction

   // One clock cycle with model checking; entered and left on a falling edge.
   task automatic run_cycle();
      int         g;
      logic       ld;
      logic [3:0] er;
      logic [3:0] v;
      #1;
      v  = iValid_AS;
      g  = mdl_grant(v, m_ptr);
      ld = (v != 0) && (!m_valid || iReady_BM);
      er = ld ? 4'(1 << g) : 4'b0000;
      chk("ready_as", 32'(oReady_AS), 32'(er));
      @(posedge iClk);
      last_g = -1;
      if (ld) begin
         // a requester held valid must not lose SIZE loads in a row
         for (int i = 0; i < SIZE; i++) begin
            if (i == g) begin
               chk("fairness", 32'(waits[i] < SIZE), 32'd1);
               waits[i] = 0;
            end else if (v[i]) waits[i]++;
         end
         m_valid = 1'b1;
         m_data  = dat[g];
         m_sel   = g;
         m_ptr   = (g + 1) % SIZE;
         last_g  = g;
      end else if (iReady_BM && m_valid) begin
         m_valid = 1'b0;
      end
      for (int i = 0; i < SIZE; i++) if (!v[i]) waits[i] = 0;
      @(negedge iClk);
      chk("valid_bm", 32'(oValid_BM), 32'(m_valid));
      chk("data_bm",  32'(oData_BM),  32'(m_data));
      chk("sel_bm",   32'(oSel_BM),   32'(m_sel));
   endtask

`ifdef RR_MERGER_PKT_LOCK_EN
   task automatic lock_step(input logic [3:0] v, input logic [7:0] d1, input logic l1,
                            input logic [3:0] e_rdy, input int e_sel, input logic e_last);
      iValid_AS   = v;
      dat[1]      = d1;
      iLast_AS[1] = l1;
      drive_data();
      #1;
      chk("lock_ready", 32'(oReady_AS), 32'(e_rdy));
      @(negedge iClk);
      chk("lock_sel",  32'(oSel_BM),  32'(e_sel));
      chk("lock_last", 32'(oLast_BM), 32'(e_last));
      if (e_sel == 1) chk("lock_data", 32'(oData_BM), 32'(d1));
   endtask
`endif

   initial begin : main
      int exp_seq [5];
      exp_seq = '{0, 1, 2, 3, 0};

      // ---- reset, with all requesters already asking ----
      iRst      = 1'b1;
      iValid_AS = 4'b1111;
      iReady_BM = 1'b1;
      for (int i = 0; i < SIZE; i++) dat[i] = 8'h10 + 8'(i);
      drive_data();
`ifdef RR_MERGER_PKT_LOCK_EN
      iLast_AS = 4'b1111;
`endif
      model_reset();
      repeat (2) @(negedge iClk);
      chk("rst_ready", 32'(oReady_AS), 32'd0);
      chk("rst_valid", 32'(oValid_BM), 32'd0);
      chk("rst_data",  32'(oData_BM),  32'd0);
      chk("rst_sel",   32'(oSel_BM),   32'd0);
      iRst = 1'b0;

      // ---- all valid, downstream ready: 0,1,2,3,0 one beat per cycle ----
      for (int k = 0; k < 5; k++) begin
         run_cycle();
         chk("rr_seq_sel",   32'(oSel_BM),   32'(exp_seq[k]));
         chk("rr_seq_valid", 32'(oValid_BM), 32'd1);
      end

      // ---- single requester 2 with 0xA5 ----
      iValid_AS = 4'b0000;
      run_cycle();
      dat[2] = 8'hA5;
      drive_data();
      iValid_AS = 4'b0100;
      #1;
      chk("single_ready", 32'(oReady_AS), 32'b0100);
      run_cycle();
      chk("single_data", 32'(oData_BM), 32'hA5);
      chk("single_sel",  32'(oSel_BM),  32'd2);

      // ---- back-pressure for 3 cycles, then drain+load together ----
      iValid_AS = 4'b0000;
      run_cycle();
      iValid_AS = 4'b1111;
      iReady_BM = 1'b0;
      run_cycle();
      for (int k = 0; k < 3; k++) begin
         run_cycle();
         chk("hold_ready", 32'(oReady_AS), 32'd0);
         chk("hold_sel",   32'(oSel_BM),   32'd3);
      end
      iReady_BM = 1'b1;
      run_cycle();
      chk("release_valid", 32'(oValid_BM), 32'd1);
      chk("release_sel",   32'(oSel_BM),   32'd0);

      // ---- pointer wrap: get ptr to 3, then requesters 0 and 3 ----
      iValid_AS = 4'b0100;
      run_cycle();
      iValid_AS = 4'b1001;
      run_cycle();
      chk("wrap_first",  32'(oSel_BM), 32'd3);
      run_cycle();
      chk("wrap_second", 32'(oSel_BM), 32'd0);

      // ---- asynchronous reset while a beat is held ----
      iValid_AS = 4'b0010;
      iReady_BM = 1'b0;
      run_cycle();
      chk("pre_rst_valid", 32'(oValid_BM), 32'd1);
      #2 iRst = 1'b1;
      #1;
      chk("async_rst_valid", 32'(oValid_BM), 32'd0);
      chk("async_rst_ready", 32'(oReady_AS), 32'd0);
      model_reset();
      @(negedge iClk);
      iRst      = 1'b0;
      iValid_AS = 4'b1111;
      iReady_BM = 1'b1;
      run_cycle();
      chk("post_rst_sel", 32'(oSel_BM), 32'd0);

      // ---- random traffic; requesters mostly hold valid until accepted ----
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < SIZE; i++) begin
            if (last_g == i) begin
               iValid_AS[i] = 1'($urandom_range(0, 1));
               dat[i]       = 8'($urandom);
            end else if (!iValid_AS[i]) begin
               iValid_AS[i] = ($urandom_range(0, 2) == 0);
               dat[i]       = 8'($urandom);
            end else if ($urandom_range(0, 19) == 0) begin
               iValid_AS[i] = 1'b0;
            end
         end
         iReady_BM = ($urandom_range(0, 3) != 0);
         drive_data();
         run_cycle();
      end

`ifdef RR_MERGER_PKT_LOCK_EN
      // ---- packet lock: requester 1 sends 3 beats while 0 keeps asking ----
      iRst      = 1'b1;
      iValid_AS = 4'b0000;
      iReady_BM = 1'b1;
      iLast_AS  = 4'b0001;
      @(negedge iClk);
      iRst = 1'b0;
      lock_step(4'b0010, 8'h21, 1'b0, 4'b0010, 1, 1'b0);
      lock_step(4'b0011, 8'h22, 1'b0, 4'b0010, 1, 1'b0);
      lock_step(4'b0011, 8'h23, 1'b1, 4'b0010, 1, 1'b1);
      lock_step(4'b0001, 8'h24, 1'b0, 4'b0001, 0, 1'b1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rr_merger.md
RR_MERGER -- requirements
Module: rr_merger

Interface
REQ-001 SHALL have parameter SIZE, default 8, number of upstream requesters (>=2).
REQ-002 SHALL have parameter WIDTH, default 32, data width per requester.
REQ-003 SHALL use derived constant IDXW = max(1, clog2(SIZE)), the grant index width.
REQ-004 SHALL have port iClk  input  1  sole clock, rising edge.
REQ-005 SHALL have port iRst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port iValid_AS  input  SIZE  per-requester valid.
REQ-007 SHALL have port oReady_AS  output  SIZE  per-requester ready, at most one bit set.
REQ-008 SHALL have port iData_AS  input  SIZE*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port oValid_BM  output  1  merged stream valid.
REQ-010 SHALL have port iReady_BM  input  1  merged stream ready.
REQ-011 SHALL have port oData_BM  output  WIDTH  merged data.
REQ-012 SHALL have port oSel_BM  output  IDXW  index of the requester that sourced oData_BM.

Function
REQ-013 SHALL compute grant g each cycle as the first requester with iValid_AS set, searching cyclically from pointer ptr upward.
REQ-014 SHALL define load = (|iValid_AS) && (!oValid_BM || iReady_BM).
REQ-015 SHALL drive oReady_AS as one-hot at bit g when load is 1, otherwise all zero.
REQ-016 SHALL on load register oData_BM <= data of g, oSel_BM <= g, oValid_BM <= 1.
REQ-017 SHALL on load set ptr <= g+1, wrapping SIZE-1 to 0.
REQ-018 SHALL on iReady_BM && oValid_BM && !load clear oValid_BM; oData_BM and oSel_BM then hold their values.
REQ-019 SHALL hold oData_BM, oSel_BM and oValid_BM stable while oValid_BM && !iReady_BM.
REQ-020 SHALL give a latency of 1 cycle from input acceptance to oValid_BM.
REQ-021 SHALL sustain one beat per cycle when iReady_BM stays high, including simultaneous drain and load.
REQ-022 SHALL guarantee that a continuously asserted requester is accepted within SIZE loads.
REQ-023 SHALL leave ptr unchanged in any cycle without a load.
REQ-024 SHALL treat a requester that drops iValid_AS before acceptance as absent, with no error state.

Reset
REQ-025 SHALL on iRst asynchronously force oValid_BM=0, oData_BM=0, oSel_BM=0 and ptr=0.
REQ-026 SHALL discard any beat held in the output register if reset asserts mid-transfer; that beat is lost.
REQ-027 SHALL keep oReady_AS all zero while iRst is high.

Configuration
REQ-028 SHALL, when macro RR_MERGER_PKT_LOCK_EN is defined, add ports iLast_AS (input, SIZE) and oLast_BM (output, 1), and register oLast_BM alongside the data.
REQ-029 SHALL with RR_MERGER_PKT_LOCK_EN lock the grant to the current requester after a load whose last bit is 0, until a load whose last bit is 1.
REQ-030 SHALL with RR_MERGER_PKT_LOCK_EN advance ptr only on loads whose last bit is 1; while locked, loads occur only from the locked requester.
REQ-031 SHALL with RR_MERGER_PKT_LOCK_EN clear the lock on reset.
REQ-032 SHALL without RR_MERGER_PKT_LOCK_EN omit the last ports and lock logic, so that every beat is arbitrated independently.

Structure
REQ-033 SHALL place the IDXW computation function and the default SIZE/WIDTH constants in the shared package rr_merger_pkg.
REQ-034 SHALL implement the cyclic priority search as the combinational sub-module rr_pick (inputs: request vector and ptr; outputs: g and any).
REQ-035 SHALL place the output register, ptr and lock state in rr_merger itself.

Verification (SIZE=4, WIDTH=8)
REQ-036 SHALL cover: reset then all iValid_AS=4'b1111, data 0x10..0x13, iReady_BM=1 -> oSel_BM sequence 0,1,2,3,0 with one beat per cycle.
REQ-037 SHALL cover: only requester 2 valid, data 0xA5 -> oReady_AS=4'b0100 one cycle, and next cycle oData_BM=0xA5, oSel_BM=2.
REQ-038 SHALL cover: output held with iReady_BM=0 for 3 cycles -> oReady_AS=0 and outputs stable; on release, back-to-back drain and load in the same cycle.
REQ-039 SHALL cover: ptr=3 with requesters 0 and 3 valid -> grant 3, then ptr wraps to 0 and grants 0.
REQ-040 SHALL cover: iRst pulsed while oValid_BM=1 -> oValid_BM=0 immediately (asynchronous) and the next grant starts from requester 0.
REQ-041 SHALL cover, with RR_MERGER_PKT_LOCK_EN: requester 1 sends a 3-beat packet while requester 0 stays valid -> oSel_BM=1,1,1 and then 0, with oLast_BM set only on the third beat.
